// File: rtl/decode_queue_if.sv
// Fetch-side and execute-side handshake bundle for decode_queue, plus flush,
// occupancy and statistics. The slave modport is the queue, master is its environment.
interface decode_queue_if #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [PC_W-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [5:0]      out_op;
  logic [4:0]      out_rs;
  logic [4:0]      out_rt;
  logic [4:0]      out_rd;
  logic [4:0]      out_shamt;
  logic [31:0]     out_imm;
  logic [25:0]     out_addr;
  logic [PC_W-1:0] out_pc;
  logic            out_illegal;
  logic [CW-1:0]   count;
  logic [31:0]     stat_total;
  logic [15:0]     stat_illegal;

  modport master (
    output flush, in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_op, out_rs, out_rt, out_rd, out_shamt,
           out_imm, out_addr, out_pc, out_illegal, count, stat_total, stat_illegal
  );

  modport slave (
    input  flush, in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_op, out_rs, out_rt, out_rd, out_shamt,
           out_imm, out_addr, out_pc, out_illegal, count, stat_total, stat_illegal
  );
endinterface

// File: rtl/decode_queue.sv
// decode_queue: decodes each fetched instruction at enqueue and buffers the record in a
// DEPTH-entry FIFO for execute. Define DECODE_STATS_EN to build push/illegal counters.
module decode_queue #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
) (
  input logic           clk,
  input logic           rst,
  decode_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [5:0]      op;
    logic [4:0]      rs;
    logic [4:0]      rt;
    logic [4:0]      rd;
    logic [4:0]      shamt;
    logic [31:0]     imm;
    logic [25:0]     addr;
    logic [PC_W-1:0] pc;
  } rec_t;

  function automatic rec_t decode(input logic [31:0] ins, input logic [PC_W-1:0] pc);
    rec_t       d;
    logic [5:0] op;
    logic [5:0] opc;
    logic [5:0] fn;
    logic       z_rs, z_rt, z_rd, z_sh;
    opc  = ins[31:26];
    fn   = ins[5:0];
    z_rs = (ins[25:21] == 5'd0);
    z_rt = (ins[20:16] == 5'd0);
    z_rd = (ins[15:11] == 5'd0);
    z_sh = (ins[10:6]  == 5'd0);
    op   = 6'd0;
    case (opc)
      6'h00: begin
        case (fn)
          6'h20: if (z_sh) op = 6'd1;
          6'h21: if (z_sh) op = 6'd2;
          6'h22: if (z_sh) op = 6'd3;
          6'h23: if (z_sh) op = 6'd4;
          6'h24: if (z_sh) op = 6'd5;
          6'h25: if (z_sh) op = 6'd6;
          6'h26: if (z_sh) op = 6'd7;
          6'h27: if (z_sh) op = 6'd8;
          6'h2A: if (z_sh) op = 6'd9;
          6'h2B: if (z_sh) op = 6'd10;
          6'h00: if (z_rs) op = 6'd11;
          6'h02: if (z_rs) op = 6'd12;
          6'h03: if (z_rs) op = 6'd13;
          6'h04: if (z_sh) op = 6'd14;
          6'h06: if (z_sh) op = 6'd15;
          6'h07: if (z_sh) op = 6'd16;
          6'h08: if (z_rt && z_rd && z_sh) op = 6'd17;
          6'h18: if (z_rd) op = 6'd32;
          6'h19: if (z_rd) op = 6'd33;
          6'h1A: if (z_rd && z_sh) op = 6'd34;
          6'h1B: if (z_rd) op = 6'd35;
          6'h12: if (z_rs && z_rt && z_sh) op = 6'd36;
          6'h10: if (z_rs && z_rt && z_sh) op = 6'd37;
          6'h11: if (z_rt && z_rd && z_sh) op = 6'd38;
          6'h13: if (z_rt && z_rd && z_sh) op = 6'd39;
          6'h09: if (z_rt) op = 6'd47;
          6'h0D: op = 6'd48;
          6'h0C: op = 6'd49;
          6'h34: op = 6'd50;
          default: ;
        endcase
      end
      6'h01: if (ins[20:16] == 5'd1) op = 6'd46;
      6'h08: op = 6'd18;
      6'h09: op = 6'd19;
      6'h0C: op = 6'd20;
      6'h0D: op = 6'd21;
      6'h0E: op = 6'd22;
      6'h0F: if (z_rs) op = 6'd23;
      6'h23: op = 6'd24;
      6'h2B: op = 6'd25;
      6'h04: op = 6'd26;
      6'h05: op = 6'd27;
      6'h0A: op = 6'd28;
      6'h0B: op = 6'd29;
      6'h02: op = 6'd30;
      6'h03: op = 6'd31;
      6'h20: op = 6'd40;
      6'h24: op = 6'd41;
      6'h21: op = 6'd42;
      6'h25: op = 6'd43;
      6'h28: op = 6'd44;
      6'h29: op = 6'd45;
      6'h10: begin
        if (ins == 32'h4200_0018)                                      op = 6'd51;
        else if (z_sh && fn == 6'h00 && ins[25:21] == 5'd0)            op = 6'd52;
        else if (z_sh && fn == 6'h00 && ins[25:21] == 5'd4)            op = 6'd53;
      end
      6'h1C: if (z_sh && fn == 6'h20) op = 6'd54;
      default: ;
    endcase

    d.op    = op;
    d.rs    = ins[25:21];
    d.rt    = (op == 6'd46) ? 5'd0 : ins[20:16];
    d.shamt = ins[10:6];
    d.addr  = ins[25:0];
    d.pc    = pc;
    if (op == 6'd31)
      d.rd = 5'd31;
    else if (op inside {[6'd1:6'd17], 6'd36, 6'd37, 6'd47, 6'd54})
      d.rd = ins[15:11];
    else
      d.rd = ins[20:16];
    if (op inside {6'd20, 6'd21, 6'd22})
      d.imm = {16'h0000, ins[15:0]};
    else if (op == 6'd23)
      d.imm = {ins[15:0], 16'h0000};
    else
      d.imm = {{16{ins[15]}}, ins[15:0]};
    return d;
  endfunction

  logic [CW-1:0] r_count;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic          r_in_ready;
  logic          r_out_valid;
  logic          r_out_illegal;
  rec_t          r_head;
  rec_t          r_mem [DEPTH];

  logic          w_push;
  logic          w_pop;
  logic          w_fwd;
  logic [CW-1:0] w_count_next;
  logic [AW-1:0] w_rd_next;
  rec_t          w_dec;
  rec_t          w_next_head;

  assign w_dec        = decode(bus.in_instr, bus.in_pc);
  assign w_push       = bus.in_valid && r_in_ready;
  assign w_pop        = bus.out_ready && r_out_valid;
  assign w_count_next = r_count + CW'(w_push) - CW'(w_pop);
  assign w_rd_next    = r_rd_ptr + AW'(w_pop);
  // Queue drains to nothing this edge, so the only possible new head is the word being pushed.
  assign w_fwd        = (r_count == CW'(w_pop));
  assign w_next_head  = w_fwd ? w_dec : r_mem[w_rd_next];

  always_ff @(posedge clk) begin
    if (w_push && !bus.flush)
      r_mem[r_wr_ptr] <= w_dec;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count       <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_in_ready    <= 1'b0;
      r_out_valid   <= 1'b0;
      r_out_illegal <= 1'b0;
      r_head        <= '0;
    end else if (bus.flush) begin
      r_count     <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_count     <= w_count_next;
      r_wr_ptr    <= r_wr_ptr + AW'(w_push);
      r_rd_ptr    <= w_rd_next;
      r_in_ready  <= (w_count_next < CW'(DEPTH));
      r_out_valid <= (w_count_next != '0);
      // Head fields only move when there is a real entry, so they hold across empty periods.
      if (w_count_next != '0) begin
        r_head        <= w_next_head;
        r_out_illegal <= (w_next_head.op == 6'd0);
      end
    end
  end

  assign bus.in_ready    = r_in_ready;
  assign bus.out_valid   = r_out_valid;
  assign bus.out_op      = r_head.op;
  assign bus.out_rs      = r_head.rs;
  assign bus.out_rt      = r_head.rt;
  assign bus.out_rd      = r_head.rd;
  assign bus.out_shamt   = r_head.shamt;
  assign bus.out_imm     = r_head.imm;
  assign bus.out_addr    = r_head.addr;
  assign bus.out_pc      = r_head.pc;
  assign bus.out_illegal = r_out_illegal;
  assign bus.count       = r_count;

`ifdef DECODE_STATS_EN
  logic [31:0] r_stat_total;
  logic [15:0] r_stat_illegal;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat_total   <= '0;
      r_stat_illegal <= '0;
    end else if (w_push && !bus.flush) begin
      r_stat_total <= r_stat_total + 32'd1;
      if (w_dec.op == 6'd0 && r_stat_illegal != 16'hFFFF)
        r_stat_illegal <= r_stat_illegal + 16'd1;
    end
  end

  assign bus.stat_total   = r_stat_total;
  assign bus.stat_illegal = r_stat_illegal;
`else
  assign bus.stat_total   = '0;
  assign bus.stat_illegal = '0;
`endif
endmodule

// File: tb/tb_decode_queue.sv
// Bench for decode_queue: directed literal cases from the instruction rules, then random
// traffic compared every cycle against a queue model with a mask/value decode table.
module tb_decode_queue;
  localparam int DEPTH = 4;
  localparam int PC_W  = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  decode_queue_if #(.DEPTH(DEPTH), .PC_W(PC_W)) bus ();
  decode_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] mask;
    logic [31:0] val;
    logic [5:0]  op;
  } pat_t;
  pat_t tbl[$];

  typedef struct {
    logic [5:0]  op;
    logic [4:0]  rs, rt, rd, shamt;
    logic [31:0] imm;
    logic [25:0] addr;
    logic [31:0] pc;
    logic        illegal;
  } m_rec_t;

  m_rec_t      mq[$];
  m_rec_t      m_last = '{default: '0};
  m_rec_t      m_nr;
  bit          m_rdy = 0;
  bit          m_push, m_pop;
  logic [31:0] m_tot = '0;
  logic [15:0] m_ill = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void addp(input logic [31:0] mask, input logic [31:0] val, input int op);
    pat_t p;
    p.mask = mask; p.val = val; p.op = 6'(op);
    tbl.push_back(p);
  endfunction

  function automatic void add_i(input int opc, input int op);
    addp(32'hFC00_0000, 32'(opc) << 26, op);
  endfunction

  function automatic void build_table();
    addp(32'hFC00_07FF, 32'h20, 1);  addp(32'hFC00_07FF, 32'h21, 2);
    addp(32'hFC00_07FF, 32'h22, 3);  addp(32'hFC00_07FF, 32'h23, 4);
    addp(32'hFC00_07FF, 32'h24, 5);  addp(32'hFC00_07FF, 32'h25, 6);
    addp(32'hFC00_07FF, 32'h26, 7);  addp(32'hFC00_07FF, 32'h27, 8);
    addp(32'hFC00_07FF, 32'h2A, 9);  addp(32'hFC00_07FF, 32'h2B, 10);
    addp(32'hFFE0_003F, 32'h00, 11); addp(32'hFFE0_003F, 32'h02, 12);
    addp(32'hFFE0_003F, 32'h03, 13); addp(32'hFC00_07FF, 32'h04, 14);
    addp(32'hFC00_07FF, 32'h06, 15); addp(32'hFC00_07FF, 32'h07, 16);
    addp(32'hFC1F_FFFF, 32'h08, 17); addp(32'hFC00_F83F, 32'h18, 32);
    addp(32'hFC00_F83F, 32'h19, 33); addp(32'hFC00_FFFF, 32'h1A, 34);
    addp(32'hFC00_F83F, 32'h1B, 35); addp(32'hFFFF_07FF, 32'h12, 36);
    addp(32'hFFFF_07FF, 32'h10, 37); addp(32'hFC1F_FFFF, 32'h11, 38);
    addp(32'hFC1F_FFFF, 32'h13, 39); addp(32'hFC1F_003F, 32'h09, 47);
    addp(32'hFC00_003F, 32'h0D, 48); addp(32'hFC00_003F, 32'h0C, 49);
    addp(32'hFC00_003F, 32'h34, 50);
    add_i(6'h08, 18); add_i(6'h09, 19); add_i(6'h0C, 20); add_i(6'h0D, 21);
    add_i(6'h0E, 22); add_i(6'h23, 24); add_i(6'h2B, 25); add_i(6'h04, 26);
    add_i(6'h05, 27); add_i(6'h0A, 28); add_i(6'h0B, 29); add_i(6'h02, 30);
    add_i(6'h03, 31); add_i(6'h20, 40); add_i(6'h24, 41); add_i(6'h21, 42);
    add_i(6'h25, 43); add_i(6'h28, 44); add_i(6'h29, 45);
    addp(32'hFFE0_0000, 32'h3C00_0000, 23);
    addp(32'hFC1F_0000, 32'h0401_0000, 46);
    addp(32'hFFFF_FFFF, 32'h4200_0018, 51);
    addp(32'hFFE0_07FF, 32'h4000_0000, 52);
    addp(32'hFFE0_07FF, 32'h4080_0000, 53);
    addp(32'hFC00_07FF, 32'h7000_0020, 54);
  endfunction

  function automatic m_rec_t mdec(input logic [31:0] w, input logic [31:0] pc);
    m_rec_t r;
    r.op = 6'd0;
    for (int i = 0; i < tbl.size(); i++)
      if (r.op == 6'd0 && (w & tbl[i].mask) == tbl[i].val) r.op = tbl[i].op;
    r.illegal = (r.op == 6'd0);
    r.rs      = w[25:21];
    r.rt      = (r.op == 6'd46) ? 5'd0 : w[20:16];
    r.shamt   = w[10:6];
    r.addr    = w[25:0];
    r.pc      = pc;
    if (r.op == 6'd31) r.rd = 5'd31;
    else if (r.op inside {[6'd1:6'd17], 6'd36, 6'd37, 6'd47, 6'd54}) r.rd = w[15:11];
    else r.rd = w[20:16];
    if (r.op inside {6'd20, 6'd21, 6'd22}) r.imm = {16'h0, w[15:0]};
    else if (r.op == 6'd23) r.imm = {w[15:0], 16'h0};
    else r.imm = {{16{w[15]}}, w[15:0]};
    return r;
  endfunction

  function automatic logic [31:0] rand_instr();
    int          k;
    int          e;
    logic [31:0] r;
    logic [31:0] w;
    k = $urandom_range(0, 9);
    r = $urandom;
    if (k < 7) begin
      e = $urandom_range(0, tbl.size() - 1);
      w = tbl[e].val | (r & ~tbl[e].mask);
      if (k == 6) w = w ^ (32'd1 << $urandom_range(0, 31));
    end else begin
      w = r;
    end
    return w;
  endfunction

  // Reference model: queue of decoded records, updated on each edge from the sampled inputs.
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      mq.delete();
      m_rdy  = 0;
      m_last = '{default: '0};
      m_tot  = '0;
      m_ill  = '0;
    end else begin
      m_push = bus.in_valid && m_rdy && (mq.size() < DEPTH);
      m_pop  = bus.out_ready && (mq.size() > 0);
      if (bus.flush) begin
        mq.delete();
      end else begin
        if (m_pop) void'(mq.pop_front());
        if (m_push) begin
          m_nr = mdec(bus.in_instr, bus.in_pc);
          mq.push_back(m_nr);
`ifdef DECODE_STATS_EN
          m_tot = m_tot + 32'd1;
          if (m_nr.illegal && m_ill != 16'hFFFF) m_ill = m_ill + 16'd1;
`endif
        end
      end
      if (mq.size() > 0) m_last = mq[0];
      m_rdy = 1;
    end
  end

  initial forever begin
    @(negedge clk);
    check("in_ready",     bus.in_ready,     64'(m_rdy && mq.size() < DEPTH));
    check("out_valid",    bus.out_valid,    64'(mq.size() != 0));
    check("count",        bus.count,        64'(mq.size()));
    check("out_op",       bus.out_op,       m_last.op);
    check("out_rs",       bus.out_rs,       m_last.rs);
    check("out_rt",       bus.out_rt,       m_last.rt);
    check("out_rd",       bus.out_rd,       m_last.rd);
    check("out_shamt",    bus.out_shamt,    m_last.shamt);
    check("out_imm",      bus.out_imm,      m_last.imm);
    check("out_addr",     bus.out_addr,     m_last.addr);
    check("out_pc",       bus.out_pc,       m_last.pc);
    check("out_illegal",  bus.out_illegal,  m_last.illegal);
    check("stat_total",   bus.stat_total,   m_tot);
    check("stat_illegal", bus.stat_illegal, m_ill);
  end

  task automatic step();
    @(negedge clk);
  endtask

  function automatic logic [31:0] addi_k(input int k);
    return 32'h2000_0000 | (32'(k) << 21) | 32'(k);
  endfunction

  initial begin
    int          idx;
    bit          hold_off;
    logic [31:0] exp_tot, exp_ill;
    build_table();
    bus.flush = 0; bus.in_valid = 0; bus.in_instr = '0; bus.in_pc = '0; bus.out_ready = 0;
    rst = 1;
    step(); step();
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_count", bus.count, 0);
    rst = 0;
    step();
    check("first_in_ready", bus.in_ready, 1);

    // add r3,r1,r2
    bus.in_valid = 1; bus.in_instr = 32'h0022_1820; bus.in_pc = 32'h100;
    step();
    bus.in_valid = 0;
    check("t1_valid", bus.out_valid, 1);
    check("t1_op", bus.out_op, 1);
    check("t1_rs", bus.out_rs, 1);
    check("t1_rt", bus.out_rt, 2);
    check("t1_rd", bus.out_rd, 3);
    check("t1_imm", bus.out_imm, 32'h0000_1820);
    check("t1_pc", bus.out_pc, 32'h100);
    bus.flush = 1;
    step();
    bus.flush = 0;
    check("t1_flushed", bus.out_valid, 0);

    // immediate extension forms
    bus.in_valid = 1; bus.in_instr = 32'h2001_FFFF; step();
    bus.in_instr = 32'h3001_FFFF; step();
    bus.in_instr = 32'h3C01_1234; step();
    bus.in_valid = 0;
    check("t2_op_addi", bus.out_op, 18);
    check("t2_imm_addi", bus.out_imm, 32'hFFFF_FFFF);
    bus.out_ready = 1; step();
    check("t2_op_andi", bus.out_op, 20);
    check("t2_imm_andi", bus.out_imm, 32'h0000_FFFF);
    step();
    check("t2_op_lui", bus.out_op, 23);
    check("t2_imm_lui", bus.out_imm, 32'h1234_0000);
    step();
    bus.out_ready = 0;
    check("t2_empty", bus.out_valid, 0);
    check("t2_hold_op", bus.out_op, 23);

    // jal then bgez
    bus.in_valid = 1; bus.in_instr = 32'h0C00_0010; step();
    bus.in_instr = 32'h0421_0004; step();
    bus.in_valid = 0;
    check("t3_op_jal", bus.out_op, 31);
    check("t3_rd_jal", bus.out_rd, 31);
    check("t3_addr_jal", bus.out_addr, 26'h10);
    bus.out_ready = 1; step();
    check("t3_op_bgez", bus.out_op, 46);
    check("t3_rt_bgez", bus.out_rt, 0);
    check("t3_imm_bgez", bus.out_imm, 32'h4);
    step();
    bus.out_ready = 0;

    // fill to full, fifth word held, then drain in order
    for (int k = 0; k < 4; k++) begin
      check("t4_in_ready", bus.in_ready, 1);
      bus.in_valid = 1; bus.in_instr = addi_k(k); bus.in_pc = 32'h200 + 32'(k * 4);
      step();
    end
    bus.in_instr = addi_k(4); bus.in_pc = 32'h210;
    step();
    check("t4_full_count", bus.count, 4);
    check("t4_full_ready", bus.in_ready, 0);
    step();
    check("t4_held_count", bus.count, 4);
    bus.out_ready = 1;
    idx = 0; hold_off = 0;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) step();
      if (hold_off) bus.in_valid = 0;
      hold_off = bus.in_valid && bus.in_ready;
      if (bus.out_valid) begin
        check("t4_order_rs", bus.out_rs, 64'(idx));
        idx++;
      end
    end
    check("t4_drained", 64'(idx), 5);
    bus.out_ready = 0; bus.in_valid = 0;

    // flush with a simultaneous push
    bus.in_valid = 1;
    for (int k = 0; k < 3; k++) begin bus.in_instr = addi_k(k + 8); step(); end
    check("t6_count3", bus.count, 3);
    bus.flush = 1; bus.in_instr = addi_k(20);
    step();
    bus.flush = 0; bus.in_valid = 0;
    check("t6_count0", bus.count, 0);
    check("t6_valid0", bus.out_valid, 0);
    check("t6_ready1", bus.in_ready, 1);
    step();
    check("t6_lost", bus.out_valid, 0);

    // asynchronous reset in the middle of a burst
    bus.in_valid = 1; bus.in_instr = addi_k(1); step(); step();
    @(posedge clk);
    #2 rst = 1;
    #1;
    check("rst_mid_valid", bus.out_valid, 0);
    check("rst_mid_ready", bus.in_ready, 0);
    check("rst_mid_count", bus.count, 0);
    check("rst_mid_op", bus.out_op, 0);
    check("rst_mid_imm", bus.out_imm, 0);
    check("rst_mid_pc", bus.out_pc, 0);
    check("rst_mid_stat", bus.stat_total, 0);
    bus.in_valid = 0;
    step();
    rst = 0;
    check("rst_rel_ready", bus.in_ready, 0);
    step();
    check("rst_rel_ready1", bus.in_ready, 1);

    // illegal encodings
    bus.in_valid = 1; bus.in_instr = 32'hFC00_0000; bus.in_pc = 32'h300; step();
    bus.in_instr = 32'h0000_0061; bus.in_pc = 32'h304; step();
    bus.in_valid = 0;
`ifdef DECODE_STATS_EN
    exp_tot = 2; exp_ill = 2;
`else
    exp_tot = 0; exp_ill = 0;
`endif
    check("t5_op0", bus.out_op, 0);
    check("t5_ill0", bus.out_illegal, 1);
    check("t5_stat_total", bus.stat_total, exp_tot);
    check("t5_stat_illegal", bus.stat_illegal, exp_ill);
    bus.out_ready = 1; step();
    check("t5_op1", bus.out_op, 0);
    check("t5_ill1", bus.out_illegal, 1);
    check("t5_pc1", bus.out_pc, 32'h304);
    step();
    bus.out_ready = 0;

    // random traffic
    for (int c = 0; c < 2000; c++) begin
      step();
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_instr  = rand_instr();
      bus.in_pc     = $urandom;
      bus.out_ready = ((c % 200) < 60) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 3) != 0);
      bus.flush     = ($urandom_range(0, 49) == 0);
    end
    step();
    bus.in_valid = 0; bus.flush = 0;
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
